// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encodings,
// default parameter values and the timeout-counter width helper.
package hazard_ctrl_pkg;

    localparam int ST_W            = 2;
    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 32;

    typedef enum logic [ST_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2,
        ST_RSVD     = 2'd3
    } state_e;

    // Bits needed to hold a wait count up to and including the timeout value.
    function automatic int to_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones. Clear loads zero plus the same-cycle
// increment, so clear together with increment starts a new count at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= W'(i_inc);
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: converts load-use, branch redirect and
// data-memory wait conditions into stage write-enables and flushes.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             id_exe_we_o,
    output logic             exe_mem_we_o,
    output logic             mem_wb_we_o,
    output logic             if_id_flush_o,
    output logic             id_exe_flush_o,
    output logic             exe_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic             redirect_o,
    output logic [1:0]       state_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int              TO_W    = to_width(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_bus_err;
    logic [TO_W-1:0] w_to_cnt;
    logic            w_mem_stall;
    logic            w_to_clr;
    logic            w_to_inc;
    logic            w_stall_inc;

    // In MEM_WAIT the freeze holds until ack, whether or not the request is still raised.
    assign w_mem_stall = ((r_state == ST_RUN) && mem_req_i && !mem_ack_i) ||
                         ((r_state == ST_MEM_WAIT) && !mem_ack_i);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bus_err <= r_bus_err || (w_state_next == ST_ERR);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = ST_RUN;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) w_state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i)                 w_state_next = ST_RUN;
                else if (w_to_cnt == TO_LAST)  w_state_next = ST_ERR;
                else                           w_state_next = ST_MEM_WAIT;
            end
            ST_ERR:  w_state_next = ST_ERR;
            default: w_state_next = ST_RUN;
        endcase
    end

    // Output logic; an acked MEM_WAIT cycle behaves exactly like RUN.
    always_comb begin
        pc_we_o         = 1'b1;
        if_id_we_o      = 1'b1;
        id_exe_we_o     = 1'b1;
        exe_mem_we_o    = 1'b1;
        mem_wb_we_o     = 1'b1;
        if_id_flush_o   = 1'b0;
        id_exe_flush_o  = 1'b0;
        exe_mem_flush_o = 1'b0;
        mem_wb_flush_o  = 1'b0;
        redirect_o      = 1'b0;
        if (rst_i) begin
            pc_we_o         = 1'b0;
            if_id_we_o      = 1'b0;
            id_exe_we_o     = 1'b0;
            exe_mem_we_o    = 1'b0;
            mem_wb_we_o     = 1'b0;
            if_id_flush_o   = 1'b1;
            id_exe_flush_o  = 1'b1;
            exe_mem_flush_o = 1'b1;
            mem_wb_flush_o  = 1'b1;
        end else if ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) begin
            if (w_mem_stall) begin
                pc_we_o        = 1'b0;
                if_id_we_o     = 1'b0;
                id_exe_we_o    = 1'b0;
                exe_mem_we_o   = 1'b0;
                mem_wb_flush_o = 1'b1;
            end else if (load_use_i) begin
                // Branch is ignored here: its operands may be the stale load target.
                pc_we_o         = 1'b0;
                if_id_we_o      = 1'b0;
                id_exe_we_o     = 1'b0;
                exe_mem_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                redirect_o     = 1'b1;
                if_id_flush_o  = 1'b1;
                id_exe_flush_o = 1'b1;
            end
        end else begin
            pc_we_o      = 1'b0;
            if_id_we_o   = 1'b0;
            id_exe_we_o  = 1'b0;
            exe_mem_we_o = 1'b0;
            mem_wb_we_o  = 1'b0;
        end
    end

    assign w_to_clr    = rst_i || !((r_state == ST_MEM_WAIT) && w_mem_stall);
    assign w_to_inc    = !rst_i && w_mem_stall;
    assign w_stall_inc = !rst_i && !pc_we_o;

    sat_counter #(.W(TO_W)) u_timeout_cnt (
        .clk   (clk_i),
        .i_clr (w_to_clr),
        .i_inc (w_to_inc),
        .o_cnt (w_to_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .i_clr (rst_i),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt_o)
    );

    assign state_o   = r_state;
    assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table for the basic
// hazards plus hand-written timeout, boundary-ack and reset sequences.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, load_use_i, branch_taken_i, mem_req_i, mem_ack_i;
    logic        pc_we_o, if_id_we_o, id_exe_we_o, exe_mem_we_o, mem_wb_we_o;
    logic        if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o;
    logic        redirect_o, bus_err_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .load_use_i      (load_use_i),
        .branch_taken_i  (branch_taken_i),
        .mem_req_i       (mem_req_i),
        .mem_ack_i       (mem_ack_i),
        .pc_we_o         (pc_we_o),
        .if_id_we_o      (if_id_we_o),
        .id_exe_we_o     (id_exe_we_o),
        .exe_mem_we_o    (exe_mem_we_o),
        .mem_wb_we_o     (mem_wb_we_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_exe_flush_o  (id_exe_flush_o),
        .exe_mem_flush_o (exe_mem_flush_o),
        .mem_wb_flush_o  (mem_wb_flush_o),
        .redirect_o      (redirect_o),
        .state_o         (state_o),
        .bus_err_o       (bus_err_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    // we = {pc, if_id, id_exe, exe_mem, mem_wb}; fl = {if_id, id_exe, exe_mem, mem_wb}
    typedef struct packed {
        logic        rst, lu, br, req, ack;
        logic [4:0]  we;
        logic [3:0]  fl;
        logic        rd;
        logic [1:0]  st;
        logic        err;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic drive(input logic r, input logic lu, input logic br,
                         input logic rq, input logic ak);
        rst_i = r; load_use_i = lu; branch_taken_i = br; mem_req_i = rq; mem_ack_i = ak;
    endtask

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
        end
    endtask

    task automatic check(input string nm, input logic [4:0] ewe, input logic [3:0] efl,
                         input logic erd, input logic [1:0] est, input logic eerr,
                         input logic [31:0] ecnt);
        logic [4:0] awe;
        logic [3:0] afl;
        awe = {pc_we_o, if_id_we_o, id_exe_we_o, exe_mem_we_o, mem_wb_we_o};
        afl = {if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o};
        $display("[%0t] %s we=%b fl=%b rd=%b st=%0d err=%b cnt=%0d",
                 $time, nm, awe, afl, redirect_o, state_o, bus_err_o, stall_cnt_o);
        cmp(nm, "we",    32'(awe),        32'(ewe));
        cmp(nm, "flush", 32'(afl),        32'(efl));
        cmp(nm, "redir", 32'(redirect_o), 32'(erd));
        cmp(nm, "state", 32'(state_o),    32'(est));
        cmp(nm, "err",   32'(bus_err_o),  32'(eerr));
        cmp(nm, "cnt",   stall_cnt_o,     ecnt);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    int exp_cnt;

    initial begin
        //          rst   lu    br    req   ack   we        fl       rd    st    err   cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 4'b1111, 1'b0, 2'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00011, 4'b0010, 1'b0, 2'd0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 4'b1100, 1'b1, 2'd0, 1'b0, 32'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001, 1'b0, 2'd0, 1'b0, 32'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001, 1'b0, 2'd1, 1'b0, 32'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001, 1'b0, 2'd1, 1'b0, 32'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 4'b0001, 1'b0, 2'd1, 1'b0, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 4'b0000, 1'b0, 2'd1, 1'b0, 32'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd5};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd5};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd5};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00001, 4'b0001, 1'b0, 2'd0, 1'b0, 32'd5};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00011, 4'b0010, 1'b0, 2'd1, 1'b0, 32'd6};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 4'b1100, 1'b1, 2'd0, 1'b0, 32'd7};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd7};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].lu, vecs[i].br, vecs[i].req, vecs[i].ack);
            #1;
            check($sformatf("vec%0d", i), vecs[i].we, vecs[i].fl, vecs[i].rd,
                  vecs[i].st, vecs[i].err, vecs[i].cnt);
            tick();
        end

        // Timeout: 16 request cycles without ack, then sticky ERR.
        exp_cnt = 7;
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            check($sformatf("to_wait%0d", k), 5'b00001, 4'b0001, 1'b0,
                  (k == 0) ? 2'd0 : 2'd1, 1'b0, 32'(exp_cnt));
            tick();
            exp_cnt++;
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            check($sformatf("err%0d", k), 5'b00000, 4'b0000, 1'b0, 2'd2, 1'b1, 32'(exp_cnt));
            tick();
            exp_cnt++;
        end

        // Reset while in ERR.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_in_err", 5'b00000, 4'b1111, 1'b0, 2'd2, 1'b1, 32'(exp_cnt));
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("after_err_rst", 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd0);

        // Ack on the 16th request cycle, where the timeout would otherwise fire.
        exp_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            check($sformatf("bnd_wait%0d", k), 5'b00001, 4'b0001, 1'b0,
                  (k == 0) ? 2'd0 : 2'd1, 1'b0, 32'(exp_cnt));
            tick();
            exp_cnt++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("bnd_ack", 5'b11111, 4'b0000, 1'b0, 2'd1, 1'b0, 32'd15);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("bnd_after", 5'b11111, 4'b0000, 1'b0, 2'd0, 1'b0, 32'd15);
        tick();

        // Reset mid-MEM_WAIT, then a full timeout proves the wait count restarted.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("rst_in_wait", 5'b00000, 4'b1111, 1'b0, 2'd1, 1'b0, 32'd18);
        tick();
        exp_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            if (k == 0)
                check("after_wait_rst", 5'b00001, 4'b0001, 1'b0, 2'd0, 1'b0, 32'd0);
            tick();
            exp_cnt++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("to_again", 5'b00000, 4'b0000, 1'b0, 2'd2, 1'b1, 32'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core: turns the forwarding unit's load-use suspend, the EXE-stage branch redirect and the data-memory handshake into per-stage register write-enables and flushes. Sits beside `forward_unit`, drives the PC and the four pipeline registers, tracks multi-cycle memory waits with a timeout FSM, and keeps a saturating stall-cycle performance counter.

## Interface
- `MEM_TIMEOUT`, 16: MEM_WAIT cycles without ack before entering ERR (≥2)
- `CNT_W`, 32: stall counter width
- `clk_i` in 1: core clock
- `rst_i` in 1: reset; synchronous and active-high
- `load_use_i` in 1: load-use suspend from forward unit (consumer in EXE, load in MEM)
- `branch_taken_i` in 1: EXE-stage branch/jump resolved taken
- `mem_req_i` in 1: MEM-stage instruction accesses data memory
- `mem_ack_i` in 1: data memory completes access this cycle
- `pc_we_o`, `if_id_we_o`, `id_exe_we_o`, `exe_mem_we_o`, `mem_wb_we_o` out 1 each: stage register enables
- `if_id_flush_o`, `id_exe_flush_o`, `exe_mem_flush_o`, `mem_wb_flush_o` out 1 each: load bubble (NOP) into that register at next edge
- `redirect_o` out 1: PC takes branch target at next edge
- `state_o` out 2: FSM state
- `bus_err_o` out 1: sticky memory-timeout error
- `stall_cnt_o` out CNT_W: cycles with `pc_we_o`=0 since reset, saturating

## Operation
- States: RUN=0, MEM_WAIT=1, ERR=2; 3 unused, decodes to RUN next cycle.
- Memory stall (RUN, `mem_req_i & ~mem_ack_i`): pc/if_id/id_exe/exe_mem we=0, `mem_wb_flush_o`=1; next state MEM_WAIT, timeout count cleared to 1.
- MEM_WAIT, no ack: same freeze; timeout count +1; when count reaches `MEM_TIMEOUT`, next state ERR.
- MEM_WAIT, `mem_ack_i`=1: outputs evaluated as RUN for this cycle (all stages advance unless another hazard); next state RUN.
- Load-use (no memory stall): pc/if_id/id_exe we=0, `exe_mem_flush_o`=1, `mem_wb_we_o`=1; exactly one cycle per assertion.
- Branch (no memory stall, no load-use): all we=1, `redirect_o`=1, `if_id_flush_o`=`id_exe_flush_o`=1.
- Priority: memory stall > load-use > branch. `branch_taken_i` is ignored while `load_use_i`=1 (operand stale); held branches are re-evaluated when the freeze lifts.
- Flush wins over we for the same register; flush is only asserted with that register's we=1 or forces the bubble regardless.
- ERR: all we=0, all flushes=0, `redirect_o`=0, `bus_err_o`=1; leaves only via reset.
- Stall counter: +1 each non-reset cycle with `pc_we_o`=0, including ERR; saturates at all-ones.

## Timing
- Enables, flushes, `redirect_o` combinational from state and inputs (same cycle); state, timeout count, `bus_err_o`, `stall_cnt_o` registered.
- Reset (sampled at edge): state RUN, timeout 0, `bus_err_o`=0, `stall_cnt_o`=0. While `rst_i`=1, all we=0, all flushes=1, `redirect_o`=0. Reset mid-MEM_WAIT or in ERR returns to RUN next edge.
- Ack on the first request cycle: no stall, no MEM_WAIT entry.
- Ack on the same cycle the count would hit `MEM_TIMEOUT`: ack wins, return to RUN.
- Load-use latency: 1 bubble; load result then forwarded from MEM/WB.

## Structure
- `hazard_ctrl_pkg`: state encodings (ST_RUN, ST_MEM_WAIT, ST_ERR), state width, default `MEM_TIMEOUT`/`CNT_W`.
- One sub-module: `sat_counter` (parameterised width, clear, inc, saturating) used for stall counter and timeout counter.

## Test plan
- Reset 3 cycles, release, idle inputs -> all we=1, flushes=0, state 0, `stall_cnt_o`=0.
- `load_use_i`=1 one cycle with `branch_taken_i`=1 -> pc/if_id/id_exe we=0, `exe_mem_flush_o`=1, `redirect_o`=0; next cycle branch alone -> `redirect_o`=1, if_id/id_exe flush; `stall_cnt_o`=1.
- `mem_req_i`=1, ack after 4 cycles -> state 1 for 4 cycles, upstream frozen, `mem_wb_flush_o`=1; ack cycle all we=1, then state 0; `stall_cnt_o`=4.
- `mem_req_i`=1, no ack, MEM_TIMEOUT=16 -> state 2 after 16 wait cycles, `bus_err_o`=1 sticky, all we=0, counter keeps incrementing.
- Ack exactly at cycle 16 -> state 0, `bus_err_o`=0.
- `rst_i` asserted mid-MEM_WAIT and in ERR -> next edge state 0, `bus_err_o`=0, counters 0.
